// File: rtl/echo_pkg.sv
// Shared types and helpers for the ultrasonic echo measurement block.
package echo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Saturation / timeout code for the default 9-bit distance output.
  localparam int DIST_MAX = 511;

  // Bits needed for a counter that runs 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/echo_debounce.sv
// Echo pin synchroniser with an optional stability filter (ECHO_GLITCH_FILTER_EN).
module echo_debounce
  import echo_pkg::*;
#(
  parameter int FILTER_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic echo,
  output logic level
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= echo;
      sync2 <= sync1;
    end
  end

`ifdef ECHO_GLITCH_FILTER_EN
  generate
    localparam int FW = cnt_width(FILTER_CYCLES);

    logic [FW-1:0] hold_cnt;
    logic          filt;

    // The clean level only follows sync2 after FILTER_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_cnt <= '0;
        filt     <= 1'b0;
      end else if (sync2 == filt) begin
        hold_cnt <= '0;
      end else if (hold_cnt == FW'(FILTER_CYCLES - 1)) begin
        hold_cnt <= '0;
        filt     <= sync2;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end

    assign level = filt;
  endgenerate
`else
  localparam int unused_filter_cycles = FILTER_CYCLES;
  assign level = sync2;
`endif

endmodule

// File: rtl/echo_measure.sv
// Converts the ultrasonic echo pulse width into centimetres; optional echo glitch filter via ECHO_GLITCH_FILTER_EN.
module echo_measure
  import echo_pkg::*;
#(
  parameter int CYCLES_PER_CM = 5800,
  parameter int DIST_W        = $clog2(DIST_MAX + 1),
  parameter int THRESH_CM     = 30,
  parameter int ARM_TIMEOUT   = 1000000,
  parameter int ECHO_TIMEOUT  = 3800000,
  parameter int FILTER_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic              echo,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_valid,
  output logic              obstacle,
  output logic              timeout
);

  localparam int SUB_W = cnt_width(CYCLES_PER_CM);
  localparam int ARM_W = cnt_width(ARM_TIMEOUT);
  localparam int LEN_W = cnt_width(ECHO_TIMEOUT);
  localparam logic [DIST_W-1:0] CM_MAX = '1;

  state_t             state;
  logic               echo_level;
  logic               echo_q;
  logic               trig_q;
  logic               timed_out;
  logic [ARM_W-1:0]   wait_cnt;
  logic [SUB_W-1:0]   sub_cnt;
  logic [DIST_W-1:0]  cm_cnt;
  logic [LEN_W-1:0]   len_cnt;

  logic echo_rise;
  logic echo_fall;
  logic trig_fall;

  echo_debounce #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .echo (echo),
    .level(echo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_q <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      echo_q <= echo_level;
      trig_q <= trig;
    end
  end

  assign echo_rise = echo_level & ~echo_q;
  assign echo_fall = ~echo_level & echo_q;
  assign trig_fall = ~trig & trig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      sub_cnt    <= '0;
      cm_cnt     <= '0;
      len_cnt    <= '0;
      timed_out  <= 1'b0;
      dist_cm    <= '0;
      dist_valid <= 1'b0;
      obstacle   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      dist_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_fall) begin
            state    <= ARMED;
            wait_cnt <= '0;
          end
        end
        // Only a fresh edge starts a measurement; a level already high on entry is stale.
        ARMED: begin
          if (echo_rise) begin
            state   <= MEASURE;
            sub_cnt <= '0;
            cm_cnt  <= '0;
            len_cnt <= '0;
          end else if (wait_cnt == ARM_W'(ARM_TIMEOUT - 1)) begin
            state     <= DONE;
            timed_out <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        MEASURE: begin
          len_cnt <= len_cnt + 1'b1;
          if (sub_cnt == SUB_W'(CYCLES_PER_CM - 1)) begin
            sub_cnt <= '0;
            if (cm_cnt != CM_MAX) cm_cnt <= cm_cnt + 1'b1;
          end else begin
            sub_cnt <= sub_cnt + 1'b1;
          end
          if (echo_fall) begin
            state     <= DONE;
            timed_out <= 1'b0;
          end else if (len_cnt == LEN_W'(ECHO_TIMEOUT - 1)) begin
            state     <= DONE;
            timed_out <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          dist_valid <= 1'b1;
          if (timed_out) begin
            dist_cm  <= CM_MAX;
            timeout  <= 1'b1;
            obstacle <= 1'b0;
          end else begin
            dist_cm  <= cm_cnt;
            timeout  <= 1'b0;
            obstacle <= (int'(cm_cnt) < THRESH_CM);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_measure.sv
// Directed self-checking bench for echo_measure (small timing constants).
module tb_echo_measure;

`ifdef ECHO_GLITCH_FILTER_EN
  localparam int FLT = 16;
`else
  localparam int FLT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trig = 1'b0;
  logic       echo = 1'b0;
  logic [8:0] dist_cm;
  logic       dist_valid;
  logic       obstacle;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int valid_count = 0;
  int vc0;
  int cyc;
  bit got;

  echo_measure #(
    .CYCLES_PER_CM(10),
    .DIST_W       (9),
    .THRESH_CM    (30),
    .ARM_TIMEOUT  (200),
    .ECHO_TIMEOUT (500),
    .FILTER_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig      (trig),
    .echo      (echo),
    .dist_cm   (dist_cm),
    .dist_valid(dist_valid),
    .obstacle  (obstacle),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dist_valid) valid_count++;

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task waitValid(input int budget, output int cycles, output bit seen);
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      if (dist_valid) seen = 1'b1;
    end
  endtask

  task pulseTrig();
    @(negedge clk) trig = 1'b1;
    @(negedge clk) trig = 1'b0;
  endtask

  // Trigger, wait, then an echo pulse of exactly width cycles at the pin.
  task applyStimulus(input int delay, input int width);
    pulseTrig();
    repeat (delay) @(negedge clk);
    echo = 1'b1;
    repeat (width) @(negedge clk);
    echo = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_dist", dist_cm, 0);
    checkOutput("rst_valid", dist_valid, 0);
    checkOutput("rst_obst", obstacle, 0);
    checkOutput("rst_tmo", timeout, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] 123-cycle echo");
    vc0 = valid_count;
    applyStimulus(5, 123);
    waitValid(60, cyc, got);
    checkOutput("t1_got", got, 1);
    checkOutput("t1_lat", cyc, 4 + FLT);
    checkOutput("t1_dist", dist_cm, 12);
    checkOutput("t1_obst", obstacle, 1);
    checkOutput("t1_tmo", timeout, 0);
    repeat (5) @(negedge clk);
    checkOutput("t1_count", valid_count, vc0 + 1);

    $display("[TB] 400-cycle echo");
    applyStimulus(5, 400);
    waitValid(60, cyc, got);
    checkOutput("t2_got", got, 1);
    checkOutput("t2_dist", dist_cm, 40);
    checkOutput("t2_obst", obstacle, 0);
    checkOutput("t2_tmo", timeout, 0);
    repeat (5) @(negedge clk);

    $display("[TB] no echo");
    pulseTrig();
    waitValid(300, cyc, got);
    checkOutput("t3_got", got, 1);
    checkOutput("t3_lat", cyc, 202);
    checkOutput("t3_dist", dist_cm, 511);
    checkOutput("t3_tmo", timeout, 1);
    checkOutput("t3_obst", obstacle, 0);
    repeat (5) @(negedge clk);

    $display("[TB] echo stuck high");
    vc0 = valid_count;
    pulseTrig();
    repeat (5) @(negedge clk);
    echo = 1'b1;
    waitValid(700, cyc, got);
    checkOutput("t4_got", got, 1);
    checkOutput("t4_lat", cyc, 504 + FLT);
    checkOutput("t4_dist", dist_cm, 511);
    checkOutput("t4_tmo", timeout, 1);
    repeat (96) @(negedge clk);
    echo = 1'b0;
    repeat (30 + FLT) @(negedge clk);
    checkOutput("t4_count", valid_count, vc0 + 1);

    $display("[TB] reset mid-measure");
    vc0 = valid_count;
    pulseTrig();
    repeat (5) @(negedge clk);
    echo = 1'b1;
    repeat (30 + FLT) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_dist", dist_cm, 0);
    checkOutput("t5_tmo", timeout, 0);
    checkOutput("t5_obst", obstacle, 0);
    echo = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10 + FLT) @(negedge clk);
    checkOutput("t5_count", valid_count, vc0);
    checkOutput("t5_valid", dist_valid, 0);
    applyStimulus(5, 50);
    waitValid(60, cyc, got);
    checkOutput("t5b_got", got, 1);
    checkOutput("t5b_dist", dist_cm, 5);
    checkOutput("t5b_obst", obstacle, 1);
    checkOutput("t5b_tmo", timeout, 0);
    repeat (5) @(negedge clk);

    $display("[TB] stale echo level at trigger");
    echo = 1'b1;
    repeat (25) @(negedge clk);
    pulseTrig();
    repeat (20) @(negedge clk);
    echo = 1'b0;
    repeat (20) @(negedge clk);
    echo = 1'b1;
    repeat (300) @(negedge clk);
    echo = 1'b0;
    waitValid(60, cyc, got);
    checkOutput("t6_got", got, 1);
    checkOutput("t6_lat", cyc, 4 + FLT);
    checkOutput("t6_dist", dist_cm, 30);
    checkOutput("t6_obst", obstacle, 0);
    checkOutput("t6_tmo", timeout, 0);
    repeat (5) @(negedge clk);

`ifdef ECHO_GLITCH_FILTER_EN
    $display("[TB] short glitches while armed");
    pulseTrig();
    repeat (5) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      echo = 1'b1;
      repeat (8) @(negedge clk);
      echo = 1'b0;
      repeat (10) @(negedge clk);
    end
    waitValid(300, cyc, got);
    checkOutput("t7_got", got, 1);
    checkOutput("t7_lat", cyc, 143);
    checkOutput("t7_dist", dist_cm, 511);
    checkOutput("t7_tmo", timeout, 1);
    repeat (5) @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
